// File: rtl/regfile_wr_arbiter.sv
// Round-robin write-port controller for the RV32I register file, with registered regfile write outputs.
// Define REGFILE_WR_ARB_INIT_EN to add a post-reset sweep that zeroes x1..x31.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      stall_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      rd_wren_o,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      init_done_o,
  output logic                      x0_drop_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef REGFILE_WR_ARB_INIT_EN
  typedef enum logic {INIT, RUN} state_e;
  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
`endif

  logic               run_en;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               found;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_data;

  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               rd_wren_q, rd_wren_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               init_done_q, init_done_d;
  logic               x0_drop_q, x0_drop_d;

`ifdef REGFILE_WR_ARB_INIT_EN
  assign run_en = (state_q == RUN);
`else
  assign run_en = 1'b1;
`endif

  // Search starts one past the last winner, so a continuously valid requester waits at most NUM_REQ transfers.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    if (run_en && !stall_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid_i[IDX_W'((int'(last_grant_q) + 1 + i) % NUM_REQ)]) begin
          found     = 1'b1;
          grant_idx = IDX_W'((int'(last_grant_q) + 1 + i) % NUM_REQ);
        end
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign win_addr = req_addr_i[grant_idx*ADDR_W +: ADDR_W];
  assign win_data = req_data_i[grant_idx*DATA_W +: DATA_W];

  always_comb begin
    last_grant_d = last_grant_q;
    rd_wren_d    = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    x0_drop_d    = 1'b0;
    init_done_d  = 1'b1;
`ifdef REGFILE_WR_ARB_INIT_EN
    state_d      = state_q;
    cnt_d        = cnt_q;
    init_done_d  = init_done_q;
    if (state_q == INIT) begin
      rd_wren_d = 1'b1;
      rd_addr_d = ADDR_W'(cnt_q);
      rd_data_d = '0;
      cnt_d     = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        state_d     = RUN;
        init_done_d = 1'b1;
        cnt_d       = 5'd1;
      end
    end
`endif
    // Writes to x0 are still consumed, but the regfile never sees them.
    if (found) begin
      last_grant_d = grant_idx;
      rd_addr_d    = win_addr;
      rd_data_d    = win_data;
      rd_wren_d    = (win_addr != '0);
      x0_drop_d    = (win_addr == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rd_wren_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      init_done_q  <= 1'b0;
      x0_drop_q    <= 1'b0;
`ifdef REGFILE_WR_ARB_INIT_EN
      state_q      <= INIT;
      cnt_q        <= 5'd1;
`endif
    end else begin
      last_grant_q <= last_grant_d;
      rd_wren_q    <= rd_wren_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      init_done_q  <= init_done_d;
      x0_drop_q    <= x0_drop_d;
`ifdef REGFILE_WR_ARB_INIT_EN
      state_q      <= state_d;
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready_o = grant;
  assign rd_wren_o   = rd_wren_q;
  assign rd_addr_o   = rd_addr_q;
  assign rd_data_o   = rd_data_q;
  assign init_done_o = init_done_q;
  assign x0_drop_o   = x0_drop_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter; follows REGFILE_WR_ARB_INIT_EN if defined.
module tb_regfile_wr_arbiter;
  localparam int NUM_REQ = 3;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic                      stall_i = 1'b0;
  logic [NUM_REQ-1:0]        req_valid_i = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data_i = '0;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      rd_wren_o;
  logic [ADDR_W-1:0]         rd_addr_o;
  logic [DATA_W-1:0]         rd_data_o;
  logic                      init_done_o;
  logic                      x0_drop_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [32];

  regfile_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .rd_wren_o(rd_wren_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .init_done_o(init_done_o), .x0_drop_o(x0_drop_o)
  );

  always #5 clk_i = ~clk_i;

  // Minimal regfile model fed by the write port; x0 stays hardwired to zero.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rd_wren_o && rd_addr_o != 5'd0) begin
      rf[rd_addr_o] <= rd_data_o;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic st);
    req_valid_i = v;
    req_addr_i  = {a2, a1, a0};
    req_data_i  = {d2, d1, d0};
    stall_i     = st;
    #1;
  endtask

  task automatic runInit();
`ifdef REGFILE_WR_ARB_INIT_EN
    for (int k = 1; k <= 31; k++) begin
      checkOutput("init_ready", 64'(req_ready_o), 64'(3'b000));
      tick();
      checkOutput("init_wren", 64'(rd_wren_o), 64'(1'b1));
      checkOutput("init_addr", 64'(rd_addr_o), 64'(k));
      checkOutput("init_data", 64'(rd_data_o), 64'(0));
      checkOutput("init_done", 64'(init_done_o), 64'(k == 31));
    end
`endif
  endtask

  initial begin
    logic [2:0]  exp_ready [6];
    logic [31:0] dv [3];
    exp_ready = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    dv = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    tick();
    tick();
    checkOutput("rst_wren", 64'(rd_wren_o), 64'(0));
    checkOutput("rst_addr", 64'(rd_addr_o), 64'(0));
    checkOutput("rst_data", 64'(rd_data_o), 64'(0));
    checkOutput("rst_init_done", 64'(init_done_o), 64'(0));
    checkOutput("rst_x0_drop", 64'(x0_drop_o), 64'(0));
    checkOutput("rst_ready", 64'(req_ready_o), 64'(0));

`ifdef REGFILE_WR_ARB_INIT_EN
    rst_ni = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      checkOutput("sweep_addr", 64'(rd_addr_o), 64'(k));
    end
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_wren", 64'(rd_wren_o), 64'(0));
    checkOutput("midrst_addr", 64'(rd_addr_o), 64'(0));
    checkOutput("midrst_done", 64'(init_done_o), 64'(0));
    tick();
`endif

    // Three requesters valid from reset release: rotate 0,1,2,0,1,2.
    rst_ni = 1'b1;
    applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, dv[0], dv[1], dv[2], 1'b0);
    runInit();
    for (int i = 0; i < 6; i++) begin
      checkOutput("rr_ready", 64'(req_ready_o), 64'(exp_ready[i]));
      tick();
      checkOutput("rr_wren", 64'(rd_wren_o), 64'(1));
      checkOutput("rr_addr", 64'(rd_addr_o), 64'(i % 3 + 1));
      checkOutput("rr_data", 64'(rd_data_o), 64'(dv[i % 3]));
      if (i == 0) checkOutput("rr_init_done", 64'(init_done_o), 64'(1));
    end

    // Single requester 1 write to x5.
    applyStimulus(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0);
    checkOutput("r1_ready", 64'(req_ready_o), 64'(3'b010));
    tick();
    checkOutput("r1_wren", 64'(rd_wren_o), 64'(1));
    checkOutput("r1_addr", 64'(rd_addr_o), 64'(5));
    checkOutput("r1_data", 64'(rd_data_o), 64'(32'hDEADBEEF));
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    checkOutput("idle_ready", 64'(req_ready_o), 64'(0));
    tick();
    checkOutput("idle_wren", 64'(rd_wren_o), 64'(0));
    checkOutput("idle_addr_hold", 64'(rd_addr_o), 64'(5));
    checkOutput("rf_x5", 64'(rf[5]), 64'(32'hDEADBEEF));

    // Write to x0 is consumed and dropped.
    applyStimulus(3'b001, 5'd0, 5'd0, 5'd0, 32'h12345678, 32'h0, 32'h0, 1'b0);
    checkOutput("x0_ready", 64'(req_ready_o), 64'(3'b001));
    tick();
    checkOutput("x0_wren", 64'(rd_wren_o), 64'(0));
    checkOutput("x0_drop", 64'(x0_drop_o), 64'(1));
    checkOutput("x0_data", 64'(rd_data_o), 64'(32'h12345678));
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    checkOutput("x0_drop_end", 64'(x0_drop_o), 64'(0));

    // Stall with requester 2 valid, then grant once stall drops.
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("stall_ready", 64'(req_ready_o), 64'(0));
      tick();
      checkOutput("stall_wren", 64'(rd_wren_o), 64'(0));
    end
    applyStimulus(3'b100, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
    checkOutput("unstall_ready", 64'(req_ready_o), 64'(3'b100));
    tick();
    checkOutput("unstall_wren", 64'(rd_wren_o), 64'(1));
    checkOutput("unstall_addr", 64'(rd_addr_o), 64'(7));
    checkOutput("unstall_data", 64'(rd_data_o), 64'(32'hA5A5A5A5));

    // Wrap-around: after requester 2, requester 0 wins over 1, then 1.
    applyStimulus(3'b011, 5'd9, 5'd10, 5'd0, 32'h9, 32'hA, 32'h0, 1'b0);
    checkOutput("wrap_ready0", 64'(req_ready_o), 64'(3'b001));
    tick();
    checkOutput("wrap_addr0", 64'(rd_addr_o), 64'(9));
    applyStimulus(3'b010, 5'd9, 5'd10, 5'd0, 32'h9, 32'hA, 32'h0, 1'b0);
    checkOutput("wrap_ready1", 64'(req_ready_o), 64'(3'b010));
    tick();
    checkOutput("wrap_addr1", 64'(rd_addr_o), 64'(10));
    checkOutput("wrap_data1", 64'(rd_data_o), 64'(32'hA));
    applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
